// File: rtl/sdram_bram_responder_if.sv
// rtl/sdram_bram_responder_if.sv - SDRAM request/response bus between arbiter (master) and controller (slave)
interface sdram_bram_responder_if;
    logic [2:0]  sdram_req;
    logic [25:0] sdram_addr;
    logic        sdram_write;
    logic        sdram_burst;
    logic [3:0]  sdram_byte_enable;
    logic [31:0] sdram_wdata;
    logic        sdram_ack;
    logic [31:0] sdram_rdata;
    logic [2:0]  sdram_rdvalid;
    logic        sdram_complete;

    modport master (
        output sdram_req,
        output sdram_addr,
        output sdram_write,
        output sdram_burst,
        output sdram_byte_enable,
        output sdram_wdata,
        input  sdram_ack,
        input  sdram_rdata,
        input  sdram_rdvalid,
        input  sdram_complete
    );

    modport slave (
        input  sdram_req,
        input  sdram_addr,
        input  sdram_write,
        input  sdram_burst,
        input  sdram_byte_enable,
        input  sdram_wdata,
        output sdram_ack,
        output sdram_rdata,
        output sdram_rdvalid,
        output sdram_complete
    );
endinterface

// File: rtl/sdram_bram_responder.sv
// rtl/sdram_bram_responder.sv - block-RAM stand-in for the SDRAM controller; optional refresh stalls under SDRAM_RESP_REFRESH_EN
module sdram_bram_responder #(
    parameter int MEM_WORDS_LOG2   = 16,
    parameter int BURST_LEN        = 8,
    parameter int REFRESH_INTERVAL = 512,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    sdram_bram_responder_if.slave bus
);
    localparam int AW = MEM_WORDS_LOG2;
    localparam int BW = $clog2(BURST_LEN);
    localparam int CW = $clog2(BURST_LEN + 1);

`ifdef SDRAM_RESP_REFRESH_EN
    typedef enum logic [1:0] {IDLE, READ, REFRESH} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ} state_t;
`endif

    state_t        state;
    logic [31:0]   mem [0:(1 << AW) - 1];
    logic [AW-1:0] req_word;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_left;
    logic [2:0]    rd_id;
    logic [2:0]    rdvalid_q;
    logic [31:0]   rdata_q;
    logic          complete_q;
    logic          ack;
    logic          unused_addr_bits;

    // Upper address bits are dropped so the memory aliases across the 26-bit space.
    assign req_word         = bus.sdram_addr[AW+1:2];
    assign unused_addr_bits = ^{bus.sdram_addr[25:AW+2], bus.sdram_addr[1:0]};

`ifdef SDRAM_RESP_REFRESH_EN
    localparam int RIW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int RCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [RIW-1:0] refresh_count;
    logic [RCW-1:0] refresh_step;
    logic           refresh_pending;
    logic           refresh_done;

    assign refresh_done = (state == REFRESH) && (refresh_step == RCW'(REFRESH_CYCLES - 1));
    assign ack = (state == IDLE) && (bus.sdram_req != 3'd0) && !reset && !refresh_pending;

    // Free-running interval counter; a new request for refresh wins over clearing the old one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_count   <= '0;
            refresh_pending <= 1'b0;
        end else begin
            if (refresh_done)
                refresh_pending <= 1'b0;
            if (refresh_count == RIW'(REFRESH_INTERVAL - 1)) begin
                refresh_count   <= '0;
                refresh_pending <= 1'b1;
            end else begin
                refresh_count <= refresh_count + RIW'(1);
            end
        end
    end
`else
    assign ack = (state == IDLE) && (bus.sdram_req != 3'd0) && !reset;
`endif

    assign bus.sdram_ack      = ack;
    assign bus.sdram_rdvalid  = rdvalid_q;
    assign bus.sdram_rdata    = rdata_q;
    assign bus.sdram_complete = complete_q;

    // Memory has no reset; contents survive reset like real SDRAM.
    always_ff @(posedge clock) begin
        if (ack && bus.sdram_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.sdram_byte_enable[b])
                    mem[req_word][8*b +: 8] <= bus.sdram_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_addr    <= '0;
            rd_left    <= '0;
            rd_id      <= '0;
            rdvalid_q  <= '0;
            rdata_q    <= '0;
            complete_q <= 1'b0;
`ifdef SDRAM_RESP_REFRESH_EN
            refresh_step <= '0;
`endif
        end else begin
            rdvalid_q  <= '0;
            rdata_q    <= '0;
            complete_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ack && !bus.sdram_write) begin
                        rd_id   <= bus.sdram_req;
                        rd_addr <= req_word;
                        rd_left <= bus.sdram_burst ? CW'(BURST_LEN) : CW'(1);
                        state   <= READ;
                    end
`ifdef SDRAM_RESP_REFRESH_EN
                    else if (refresh_pending) begin
                        refresh_step <= '0;
                        state        <= REFRESH;
                    end
`endif
                end
                READ: begin
                    rdvalid_q  <= rd_id;
                    rdata_q    <= mem[rd_addr];
                    complete_q <= (rd_left == CW'(1));
                    // Wrap inside the aligned burst block: only the low bits advance.
                    rd_addr    <= {rd_addr[AW-1:BW], rd_addr[BW-1:0] + BW'(1)};
                    rd_left    <= rd_left - CW'(1);
                    if (rd_left == CW'(1))
                        state <= IDLE;
                end
`ifdef SDRAM_RESP_REFRESH_EN
                REFRESH: begin
                    refresh_step <= refresh_step + RCW'(1);
                    if (refresh_done)
                        state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
